// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers for the synchronous FIFO slice.
package sync_fifo_pkg;

  // Default address width; the FIFO holds 2**ADDR_WIDTH words.
  localparam int ADDR_WIDTH_DEFAULT = 4;

  // Pointer width for the default configuration: address bits plus one wrap bit.
  localparam int PTR_WIDTH = ADDR_WIDTH_DEFAULT + 1;

  // Number of storage entries for a given address width.
  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Pointer width for a given address width (extra MSB distinguishes full from empty).
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer-facing bundle of the synchronous FIFO.
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
);

  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  // User side: issues requests and write data, observes data and status.
  modport master (
    output wr_en, rd_en, din,
    input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  // FIFO side: accepts requests, drives data and status.
  modport slave (
    input  wr_en, rd_en, din,
    output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port and one
// read port whose output register resets to zero and holds when not enabled.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Storage array: written on accepted writes only, never reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read output register: loads the addressed word on an accepted read, otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= {DATA_WIDTH{1'b0}};
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end else begin
      rd_data_q <= rd_data_q;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointer, occupancy and flag logic around a register-array
// memory with a registered read port (one-cycle read latency, no fall-through).
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int AF_LEVEL   = fifo_depth(ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 2
) (
  input logic        clk,
  input logic        rst,
  sync_fifo_if.slave bus
);

  localparam int PW = ptr_width(ADDR_WIDTH);

  localparam logic [PW-1:0] ONE_C      = PW'(1);
  localparam logic [PW-1:0] AF_LEVEL_C = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_LEVEL_C = PW'(AE_LEVEL);

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  full_s;
  logic                  empty_s;
  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic [DATA_WIDTH-1:0] rd_data_s;

  // Full/empty come from the pointers: equal means empty, same slot on opposite laps means full.
  assign empty_s  = (wr_ptr_q == rd_ptr_q);
  assign full_s   = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                    (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);

  // Requests against a full/empty FIFO are dropped and touch no state.
  assign wr_acc_s = bus.wr_en & ~full_s;
  assign rd_acc_s = bus.rd_en & ~empty_s;

  // Next-state for pointers, occupancy and the request-dropped pulses.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;

    if (wr_acc_s) begin
      wr_ptr_d = wr_ptr_q + ONE_C;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_acc_s) begin
      rd_ptr_d = rd_ptr_q + ONE_C;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase

    overflow_d  = bus.wr_en & full_s;
    underflow_d = bus.rd_en & empty_s;
  end

  // State registers; reset discards all buffered data at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      count_q     <= {PW{1'b0}};
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_acc_s),
    .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wr_data_i (bus.din),
    .rd_en_i   (rd_acc_s),
    .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_data_o (rd_data_s)
  );

  assign bus.dout         = rd_data_s;
  assign bus.full         = full_s;
  assign bus.empty        = empty_s;
  assign bus.almost_full  = (count_q >= AF_LEVEL_C);
  assign bus.almost_empty = (count_q <= AE_LEVEL_C);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: a queue-based reference model predicts
// occupancy, flags and the data order; a monitor checks dout every cycle.
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  localparam int DEPTH = 16;

  logic clk;
  logic rst;

  sync_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  sync_fifo #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] model_q[$];   // words currently held by the FIFO, oldest first
  logic [7:0] exp_q[$];     // words popped at the last edge, awaiting appearance on dout
  logic [7:0] hold_val;     // value dout must show when no new word arrives
  logic       ovf_m;
  logic       udf_m;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void check_flags();
    int n;
    n = model_q.size();
    check("count",        32'(bus.count),        32'(n));
    check("full",         32'(bus.full),         32'(n == DEPTH));
    check("empty",        32'(bus.empty),        32'(n == 0));
    check("almost_full",  32'(bus.almost_full),  32'(n >= 14));
    check("almost_empty", 32'(bus.almost_empty), 32'(n <= 2));
    check("overflow",     32'(bus.overflow),     32'(ovf_m));
    check("underflow",    32'(bus.underflow),    32'(udf_m));
  endfunction

  // Monitor: one-cycle read latency, so a word popped at a rising edge must be
  // on dout by the following falling edge; otherwise dout holds.
  always @(negedge clk) begin
    if (exp_q.size() > 0) hold_val = exp_q.pop_front();
    check("dout", 32'(bus.dout), 32'(hold_val));
  end

  // One clock of stimulus; called at a falling edge, returns at the next one.
  task automatic cycle(input logic wr, input logic rd, input logic [7:0] d);
    logic full_m, empty_m, wa, ra;
    bus.wr_en = wr;
    bus.rd_en = rd;
    bus.din   = d;
    full_m  = (model_q.size() == DEPTH);
    empty_m = (model_q.size() == 0);
    wa = wr && !full_m;
    ra = rd && !empty_m;
    @(posedge clk);
    if (ra) exp_q.push_back(model_q.pop_front());
    if (wa) model_q.push_back(d);
    ovf_m = wr && full_m;
    udf_m = rd && empty_m;
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    check_flags();
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_q.delete();
    hold_val = 8'h00;
    ovf_m    = 1'b0;
    udf_m    = 1'b0;
  endtask

  // Asynchronous reset in the low phase: outputs must clear before any edge.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full",  32'(bus.full),  32'd0);
    check("rst_dout",  32'(bus.dout),  32'd0);
    check("rst_ae",    32'(bus.almost_empty), 32'd1);
    check("rst_af",    32'(bus.almost_full),  32'd0);
    check("rst_ovf",   32'(bus.overflow),     32'd0);
    check("rst_udf",   32'(bus.underflow),    32'd0);
    @(negedge clk);
    check_flags();
    #2;
    rst = 1'b0;
    @(negedge clk);
    check_flags();
  endtask

  initial begin
    rst       = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.din   = 8'h00;
    model_reset();
    #2;
    check("por_count", 32'(bus.count), 32'd0);
    check("por_empty", 32'(bus.empty), 32'd1);
    check("por_dout",  32'(bus.dout),  32'd0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);

    // Idle: nothing may change.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00);

    // Fill and drain 8.
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 8'(i));
    for (int i = 0; i < 8; i++)  cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);

    // Fill past full: 17th write overflows and is lost.
    for (int i = 0; i < 17; i++) cycle(1'b1, 1'b0, 8'(8'h10 + i));
    cycle(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 17; i++) cycle(1'b0, 1'b1, 8'h00);

    // Underflow on empty; dout holds 0x1F.
    cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);

    // Simultaneous access at count 5, then at full, then at empty.
    for (int i = 0; i < 5; i++)  cycle(1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 8'(8'h50 + i));
    for (int i = 0; i < 11; i++) cycle(1'b1, 1'b0, 8'(8'h60 + i));
    cycle(1'b1, 1'b1, 8'hEE);
    for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b1, 1'b1, 8'hA5);
    cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);

    // Randomized streaming at varying fill bias; pointers wrap many times.
    for (int blk = 0; blk < 8; blk++) begin
      int wp;
      int rp;
      wp = $urandom_range(20, 90);
      rp = $urandom_range(20, 90);
      for (int i = 0; i < 50; i++) begin
        cycle(($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < rp), 8'($urandom));
      end
    end

    // Reset in the middle of traffic discards buffered data.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'(8'hC0 + i));
    cycle(1'b0, 1'b1, 8'h00);
    async_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'(8'hD0 + i));
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock first-in/first-out data buffer with registered read data, status flags and an occupancy count. It decouples a producer and a consumer that share one clock, and serves as the generic elastic buffer in datapaths. Write and read are independent enable-qualified requests. Status flags are derived from the pointers.

Parameters:
DATA_WIDTH, 8, width of each stored word.
ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH (default 16 entries).
AF_LEVEL, DEPTH-2, occupancy at or above which almost_full asserts.
AE_LEVEL, 2, occupancy at or below which almost_empty asserts.

Ports:
clk  input  1  single clock; all state changes on the rising edge.
rst  input  1  reset, asynchronous, active-high.
wr_en  input  1  write request; din is captured if accepted.
rd_en  input  1  read request; the oldest word is popped if accepted.
din  input  DATA_WIDTH  write data.
dout  output  DATA_WIDTH  registered read data.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
almost_full  output  1  count >= AF_LEVEL.
almost_empty  output  1  count <= AE_LEVEL.
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
overflow  output  1  one-cycle pulse when wr_en is high while full.
underflow  output  1  one-cycle pulse when rd_en is high while empty.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, on port rst.
- While rst is high:
  - wr_ptr, rd_ptr and count are 0.
  - dout = 0, overflow = 0, underflow = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - Memory contents are not reset.
- Reset may assert at any time, including mid-transfer. All in-flight data is discarded immediately, without waiting for a clock edge.
- Pointers are ADDR_WIDTH+1 bits. The low ADDR_WIDTH bits address memory; the MSB is the wrap bit.
  - empty when the pointers are equal.
  - full when the low bits are equal and the MSBs differ.
- Write accept condition: wr_acc = wr_en & ~full. On wr_acc, mem[wr_ptr] <= din and wr_ptr increments, wrapping naturally.
- Read accept condition: rd_acc = rd_en & ~empty. On rd_acc, dout <= mem[rd_ptr] and rd_ptr increments.
- Read latency is 1 cycle: data is valid on dout after the edge that accepted rd_en. There is no first-word fall-through.
- When no read is accepted, dout holds its last value.
- Simultaneous wr_en and rd_en:
  - Not full and not empty: both are accepted and count is unchanged.
  - Full: only the read is accepted, the write is dropped and overflow pulses.
  - Empty: only the write is accepted, the read is dropped, underflow pulses and dout holds.
- count changes by +1 on a write only, -1 on a read only, and 0 when both or neither are accepted. count is registered.
- full, empty, almost_full and almost_empty are combinational decodes of the registered pointers and count. They therefore update in the same cycle the edge occurs.
- Dropped requests never modify memory, pointers or count.
- Wrap-around: after DEPTH writes and reads the pointers roll over. Data order is preserved across the wrap.

Decomposition:
- Package sync_fifo_pkg holds:
  - the DEPTH derivation function (2**ADDR_WIDTH);
  - a localparam for the pointer width (ADDR_WIDTH+1).
- One sub-module, sync_fifo_mem: a DEPTH x DATA_WIDTH register array with one synchronous write port and one synchronous registered read port. The read port has a read enable and an output register that resets to 0.
- Pointer, count and flag logic stay in the top level.

Test Plan:
- Reset then idle. Assert rst mid-cycle with clk=0 → empty=1, full=0, count=0, dout=0 immediately without a clock edge; no flag changes while idle.
- Fill and drain 8. Write 1..8 on consecutive cycles, then read 8 times → count rises to 8 and falls back to 0; dout shows 1..8 in order, each one cycle after its read; empty=1 at the end.
- Full and overflow. Write 17 words 0x10..0x20 → full=1 after 16; the 17th write pulses overflow for one cycle and count stays 16. Draining returns 0x10..0x1F; 0x20 is never seen.
- Underflow. rd_en on an empty FIFO → underflow pulses, dout holds its previous value, count stays 0.
- Simultaneous access. With count=5, hold wr_en and rd_en for 10 cycles → count stays 5 and data order is preserved. With full, assert both → count becomes 15 and overflow=1. With empty, assert both → count becomes 1 and underflow=1.
- Wrap and thresholds. Stream 40 words through at a varying fill level → pointers wrap twice and order is intact. almost_full asserts at count 14 and almost_empty deasserts at count 3 with the default parameters.
